// File: rtl/regfile_sb.sv
// Parametrised 2R/1W flop register file with write bypass, per-register busy
// scoreboard for issue stalls, and a sequenced bulk-clear sweep.

module regfile_sb_rport #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1
) (
    input  logic [ADDR_W-1:0]                    raddr,
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]   regs,
    input  logic [(1<<ADDR_W)-1:0]               busy,
    input  logic                                 wr_qual,
    input  logic [ADDR_W-1:0]                    waddr,
    input  logic [DATA_W-1:0]                    wdata,
    output logic [DATA_W-1:0]                    rdata,
    output logic                                 rbusy
);
    always_comb begin
        rdata = regs[raddr];
        rbusy = busy[raddr];
        if (BYPASS != 0 && wr_qual && waddr == raddr) begin
            rdata = wdata;
            rbusy = 1'b0;
        end
        if (ZERO_R0 != 0 && raddr == '0) begin
            rdata = '0;
            rbusy = 1'b0;
        end
    end
endmodule

module regfile_sb #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              rbusy1,
    output logic              rbusy2,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ok,
    input  logic              clr_req,
    output logic              clr_busy
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NPORT = 2;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                          state_q, state_d;
    logic [ADDR_W-1:0]               cnt_q, cnt_d;
    logic [DEPTH-1:0][DATA_W-1:0]    regs_q, regs_d;
    logic [DEPTH-1:0]                busy_q, busy_d;

    logic                            wr_qual, r0_rsv, eff_busy, rsv_set;
    logic [NPORT-1:0][ADDR_W-1:0]    raddr;
    logic [NPORT-1:0][DATA_W-1:0]    rdata;
    logic [NPORT-1:0]                rbusy;

    assign clr_busy = (state_q == SWEEP);
    assign wr_qual  = wen && !clr_busy && !(ZERO_R0 != 0 && waddr == '0);

    // A same-cycle writeback frees the register for reservation even without read bypass.
    assign r0_rsv   = (ZERO_R0 != 0) && (rsv_addr == '0);
    assign eff_busy = busy_q[rsv_addr] && !(wr_qual && waddr == rsv_addr);
    assign rsv_ok   = rsv_en && !clr_busy && (r0_rsv || !eff_busy);
    assign rsv_set  = rsv_ok && !r0_rsv;

    assign raddr  = {raddr2, raddr1};
    assign rdata1 = rdata[0];
    assign rdata2 = rdata[1];
    assign rbusy1 = rbusy[0];
    assign rbusy2 = rbusy[1];

    for (genvar p = 0; p < NPORT; p++) begin : g_rport
        regfile_sb_rport #(
            .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(ZERO_R0), .BYPASS(BYPASS)
        ) u_rport (
            .raddr  (raddr[p]),
            .regs   (regs_q),
            .busy   (busy_q),
            .wr_qual(wr_qual),
            .waddr  (waddr),
            .wdata  (wdata),
            .rdata  (rdata[p]),
            .rbusy  (rbusy[p])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                regs_d[cnt_q] = '0;
                busy_d[cnt_q] = 1'b0;
                cnt_d         = cnt_q + 1'b1;
                if (&cnt_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reserve is applied after the write so it wins on a same-address collision.
        if (wr_qual) begin
            regs_d[waddr] = wdata;
            busy_d[waddr] = 1'b0;
        end
        if (rsv_set) busy_d[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            regs_q  <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            regs_q  <= regs_d;
            busy_q  <= busy_d;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: two instances (default, and ZERO_R0=1/BYPASS=0)
// driven in lockstep against an array-based reference model.

module tb_regfile_sb;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wen = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic [AW-1:0] raddr1 = '0, raddr2 = '0, rsv_addr = '0;
    logic          rsv_en = 1'b0, clr_req = 1'b0;

    logic [DW-1:0] o_rd1 [2];
    logic [DW-1:0] o_rd2 [2];
    logic          o_rb1 [2];
    logic          o_rb2 [2];
    logic          o_ok  [2];
    logic          o_cb  [2];

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(0), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(o_rd1[0]), .rdata2(o_rd2[0]),
        .rbusy1(o_rb1[0]), .rbusy2(o_rb2[0]), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rsv_ok(o_ok[0]), .clr_req(clr_req), .clr_busy(o_cb[0]));

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1), .BYPASS(0)) dut_z (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(o_rd1[1]), .rdata2(o_rd2[1]),
        .rbusy1(o_rb1[1]), .rbusy2(o_rb2[1]), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rsv_ok(o_ok[1]), .clr_req(clr_req), .clr_busy(o_cb[1]));

    typedef struct packed {
        logic [31:0]          id;
        logic [1:0][DW-1:0]   rd1;
        logic [1:0][DW-1:0]   rd2;
        logic [1:0]           rb1;
        logic [1:0]           rb2;
        logic [1:0]           ok;
        logic                 cb;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_id = 0;

    // Reference model: config 0 = plain regs with bypass, config 1 = zero-r0, no bypass.
    int            zr [2] = '{0, 1};
    int            bp [2] = '{1, 0};
    logic [DW-1:0] mem [2][N];
    bit            bsy [2][N];
    bit            sw;
    int            sidx;

    task automatic model_reset();
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < N; i++) begin
                mem[c][i] = '0;
                bsy[c][i] = 1'b0;
            end
        sw   = 1'b0;
        sidx = 0;
    endtask

    function automatic bit wq(int c);
        return wen && !sw && !(zr[c] != 0 && waddr == 0);
    endfunction

    function automatic bit okf(int c);
        bit eb;
        if (!rsv_en || sw) return 1'b0;
        if (zr[c] != 0 && rsv_addr == 0) return 1'b1;
        eb = bsy[c][rsv_addr];
        if (wq(c) && waddr == rsv_addr) eb = 1'b0;
        return !eb;
    endfunction

    task automatic rd(input int c, input int a, output logic [DW-1:0] d, output logic b);
        d = mem[c][a];
        b = bsy[c][a];
        if (bp[c] != 0 && wq(c) && int'(waddr) == a) begin
            d = wdata;
            b = 1'b0;
        end
        if (zr[c] != 0 && a == 0) begin
            d = '0;
            b = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit ok;
        if (rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < 2; c++) begin
            if (sw) begin
                mem[c][sidx] = '0;
                bsy[c][sidx] = 1'b0;
            end else begin
                ok = okf(c);
                if (wq(c)) begin
                    mem[c][waddr] = wdata;
                    bsy[c][waddr] = 1'b0;
                end
                if (ok && !(zr[c] != 0 && rsv_addr == 0)) bsy[c][rsv_addr] = 1'b1;
            end
        end
        if (sw) begin
            sidx++;
            if (sidx == N) begin
                sw   = 1'b0;
                sidx = 0;
            end
        end else if (clr_req) begin
            sw   = 1'b1;
            sidx = 0;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        logic [DW-1:0] d;
        logic b;
        e.id = cyc_id;
        for (int c = 0; c < 2; c++) begin
            rd(c, int'(raddr1), d, b); e.rd1[c] = d; e.rb1[c] = b;
            rd(c, int'(raddr2), d, b); e.rd2[c] = d; e.rb2[c] = b;
            e.ok[c] = okf(c);
        end
        e.cb = sw;
        q.push_back(e);
        cyc_id++;
    endtask

    task automatic drive(input logic r, input logic w, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic re,
                         input logic [AW-1:0] ra, input logic cr);
        @(posedge clk);
        model_edge();
        #1;
        rst = r; wen = w & ~r; waddr = wa; wdata = wd;
        raddr1 = a1; raddr2 = a2; rsv_en = re & ~r; rsv_addr = ra; clr_req = cr;
        if (r) model_reset();
        push_exp();
    endtask

    task automatic idle(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        drive(1'b0, 1'b0, '0, '0, a1, a2, 1'b0, '0, 1'b0);
    endtask

    task automatic chk(input string name, input int id, input int c,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cfg%0d cycle %0d: got %0h expected %0h", name, c, id, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            for (int c = 0; c < 2; c++) begin
                chk("rdata1",   e.id, c, 32'(o_rd1[c]), 32'(e.rd1[c]));
                chk("rdata2",   e.id, c, 32'(o_rd2[c]), 32'(e.rd2[c]));
                chk("rbusy1",   e.id, c, 32'(o_rb1[c]), 32'(e.rb1[c]));
                chk("rbusy2",   e.id, c, 32'(o_rb2[c]), 32'(e.rb2[c]));
                chk("rsv_ok",   e.id, c, 32'(o_ok[c]),  32'(e.ok[c]));
                chk("clr_busy", e.id, c, 32'(o_cb[c]),  32'(e.cb));
            end
        end
    end

    initial begin
        model_reset();
        // Reset state, then write r3 and read it back on both ports.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 3, 8'hA5, 3, 0, 0, 0, 0);
        idle(3, 3);
        for (int i = 0; i < N; i += 2) idle(AW'(i), AW'(i + 1));
        // Same-cycle bypass (config 1 shows the old value).
        drive(0, 1, 5, 8'h3C, 5, 3, 0, 0, 0);
        idle(5, 5);
        // Reserve r7, re-reserve rejected, write+reserve same edge.
        drive(0, 0, 0, 0, 7, 7, 1, 7, 0);
        drive(0, 0, 0, 0, 7, 7, 1, 7, 0);
        drive(0, 1, 7, 8'h11, 7, 7, 1, 7, 0);
        idle(7, 7);
        // Register 0 write and reservation.
        drive(0, 1, 0, 8'hFF, 0, 0, 1, 0, 0);
        idle(0, 0);
        // Fill, then sweep with a dropped write and an ignored second request.
        for (int i = 0; i < N; i++) drive(0, 1, AW'(i), DW'(8'h40 + i), AW'(i), 2, 1, AW'(i), 0);
        drive(0, 0, 0, 0, 2, 9, 0, 0, 1);
        for (int k = 0; k < N + 2; k++) begin
            if (k == 3)      drive(0, 1, 2, 8'h77, 2, 3, 1, 4, 0);
            else if (k == 5) drive(0, 0, 0, 0, 2, 3, 0, 0, 1);
            else             idle(AW'(k), AW'(k + 7));
        end
        for (int i = 0; i < N; i += 2) idle(AW'(i), AW'(i + 1));
        // Refill, start a sweep and reset it asynchronously at sweep cycle 6.
        for (int i = 0; i < N; i++) drive(0, 1, AW'(i), DW'(8'h90 + i), 1, 2, 1, AW'(N - 1 - i), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 6; k++) idle(AW'(k), 15);
        drive(1, 0, 0, 0, 14, 15, 0, 0, 0);
        drive(1, 0, 0, 0, 13, 15, 0, 0, 0);
        for (int k = 0; k < 4; k++) idle(AW'(k + 10), AW'(k));
        for (int i = 0; i < N; i += 2) idle(AW'(i), AW'(i + 1));
        // Randomized traffic.
        for (int k = 0; k < 500; k++)
            drive(logic'($urandom_range(0, 199) == 0), logic'($urandom_range(0, 1)),
                  AW'($urandom), DW'($urandom), AW'($urandom), AW'($urandom),
                  logic'($urandom_range(0, 1)), AW'($urandom),
                  logic'($urandom_range(0, 39) == 0));
        idle(0, 0);
        for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the 16x8 two-read/one-write register file used by the core datapath.
- Adds generic width and depth.
- Optional hardwired-zero register 0.
- Write-to-read bypass.
- Per-register busy scoreboard so issue logic can stall on pending writebacks.
- Sequenced bulk-clear engine that zeroes the whole file without a reset.
- Sits between decode/issue (reads, reservations) and writeback (writes).

Parameters:
- DATA_W, 8, register width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
- ZERO_R0, 0, 1 = register 0 always reads 0, ignores writes, never busy
- BYPASS, 1, 1 = same-cycle write data/busy-clear forwarded to read ports

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wen  in  1  write enable (writeback)
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- raddr1  in  ADDR_W  read port 1 address
- raddr2  in  ADDR_W  read port 2 address
- rdata1  out  DATA_W  read port 1 data (combinational)
- rdata2  out  DATA_W  read port 2 data (combinational)
- rbusy1  out  1  register at raddr1 has a pending write
- rbusy2  out  1  register at raddr2 has a pending write
- rsv_en  in  1  reserve request (mark destination busy at issue)
- rsv_addr  in  ADDR_W  register to reserve
- rsv_ok  out  1  reservation accepted this cycle (combinational)
- clr_req  in  1  start bulk clear
- clr_busy  out  1  clear sweep in progress

Behaviour:
- Reset (async, rst=1):
  - All DEPTH registers = 0, all busy bits = 0, FSM = IDLE, sweep counter = 0.
  - Outputs after reset: rdata* = 0, rbusy* = 0, clr_busy = 0.
  - Storage is flop-based so it can be reset; inferred RAM is not allowed.
- Write:
  - Qualified write: wen=1 AND clr_busy=0 AND NOT (ZERO_R0 AND waddr=0).
  - On the clock edge it stores wdata and clears busy[waddr].
  - wen is ignored while clr_busy=1.
- Read:
  - Combinational, zero latency: rdataN = reg[raddrN].
  - With ZERO_R0=1 and raddrN=0: rdataN = 0 and rbusyN = 0.
- Bypass (BYPASS=1 only):
  - If a qualified write targets raddrN in the same cycle, rdataN = wdata and rbusyN = 0.
  - With BYPASS=0, reads return pre-edge storage and busy state.
- Reservation:
  - rsv_ok = rsv_en AND clr_busy=0 AND effective busy[rsv_addr]=0.
  - "Effective" busy includes a same-cycle qualified write clear, regardless of BYPASS.
  - With ZERO_R0=1 and rsv_addr=0: rsv_ok = rsv_en, and no bit is set.
  - rsv_ok=1 sets busy[rsv_addr] on the edge.
  - A request with rsv_ok=0 has no effect; the requester must hold and retry.
- Same-edge write and reservation to the same address: busy ends at 1 (reserve wins) and the data is stored.
- Clear FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP on clr_req=1; counter = 0.
  - In SWEEP, each edge: reg[counter] = 0, busy[counter] = 0, counter += 1.
  - After writing DEPTH-1: SWEEP -> IDLE, counter wraps to 0.
  - clr_busy=1 for exactly DEPTH cycles, starting the cycle after clr_req is sampled.
  - clr_req during SWEEP is ignored.
  - Reads during SWEEP return current storage, with no bypass.
- Reset asserted mid-sweep: immediate return to IDLE with everything zeroed; no residual sweep after rst drops.
- Address wrap: all addresses are exactly ADDR_W bits, so no out-of-range access exists.

Test Plan:
- Reset, then write 0xA5 to r3 and read r3 on both ports next cycle -> rdata1 = rdata2 = 0xA5; all other registers read 0x00.
- BYPASS=1: wen=1, waddr=5, wdata=0x3C, raddr1=5 in the same cycle -> rdata1 = 0x3C combinationally. BYPASS=0 -> old value (0x00).
- Reserve r7 (rsv_ok=1); next cycle re-reserve r7 -> rsv_ok=0, rbusy1=1 with raddr1=7. Write r7 with 0x11 and rsv_en for r7 in the same cycle -> rsv_ok=1, data = 0x11, busy stays 1.
- ZERO_R0=1: write 0xFF to r0 and reserve r0 -> rdata1 = 0x00, rbusy1 = 0, rsv_ok = 1.
- Fill all 16 registers, pulse clr_req -> clr_busy high for exactly 16 cycles. A wen to r2 mid-sweep is dropped; a second clr_req is ignored. Afterwards all registers = 0 and all busy = 0.
- Assert rst asynchronously (between edges) at sweep cycle 6 -> clr_busy drops immediately, all state = 0; after release the FSM stays IDLE.
